// File: rtl/jtag_scheduler_if.sv
// jtag_scheduler_if: requester commands, engine control and instruction-FIFO write bundle
interface jtag_scheduler_if #(
    parameter int DATA_INSTRACTION = 10
);
    logic [1:0]                  req;
    logic [1:0]                  req_op;
    logic [15:0]                 req_len0;
    logic [15:0]                 req_len1;
    logic [DATA_INSTRACTION-1:0] req_ir0;
    logic [DATA_INSTRACTION-1:0] req_ir1;
    logic [1:0]                  grant;
    logic [1:0]                  done;
    logic [1:0]                  err;
    logic [15:0]                 len;
    logic                        op;
    logic                        work;
    logic                        busy;
    logic [DATA_INSTRACTION-1:0] wdata_ir;
    logic                        wr_ir;
    logic                        full_ir;
    logic [15:0]                 xfer_count;
    modport master (
        output req, req_op, req_len0, req_len1, req_ir0, req_ir1, busy, full_ir,
        input  grant, done, err, len, op, work, wdata_ir, wr_ir, xfer_count
    );
    modport slave (
        input  req, req_op, req_len0, req_len1, req_ir0, req_ir1, busy, full_ir,
        output grant, done, err, len, op, work, wdata_ir, wr_ir, xfer_count
    );
endinterface

// File: rtl/jtag_scheduler.sv
// jtag_scheduler: round-robin two-requester scheduler driving the JTAG shift engine
module jtag_scheduler #(
    parameter int DATA_INSTRACTION = 10,
    parameter int START_TIMEOUT    = 8,
    parameter int RUN_TIMEOUT      = 4096
) (
    input logic            clk,
    input logic            rst,
    jtag_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, RUN, DONE, ERR} state_t;
    localparam logic [15:0] ST_LIM = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] RT_LIM = 16'(RUN_TIMEOUT - 1);
    state_t state_q, state_d;
    logic rr_q, rr_d, op_q, op_d, work_q, work_d, wr_q, wr_d;
    logic [1:0] grant_q, grant_d, done_q, done_d, err_q, err_d;
    logic [15:0] len_q, len_d, cnt_q, cnt_d, timer_q, timer_d;
    logic [DATA_INSTRACTION-1:0] ir_q, ir_d, wdata_q, wdata_d;
    logic win, win_op, take, fin, timing;
    logic [15:0] win_len;
    logic [DATA_INSTRACTION-1:0] win_ir;
    assign win     = (&bus.req) ? rr_q : bus.req[1];
    assign win_len = win ? bus.req_len1 : bus.req_len0;
    assign win_ir  = win ? bus.req_ir1 : bus.req_ir0;
    assign win_op  = bus.req_op[win];
    assign take    = state_q == IDLE && |bus.req;
    assign fin     = state_q == DONE || state_q == ERR;
    assign timing  = state_q inside {START, WAIT_BUSY, RUN};
    always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
    // Data shifts have nothing to load, so they skip LOAD and start a cycle earlier.
    // The first WAIT_BUSY cycle is the work pulse itself; busy seen there is stale.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (|bus.req) state_d = win_len == '0 ? ERR : win_op ? START : LOAD;
            LOAD:      state_d = bus.full_ir ? LOAD : START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = bus.busy && !work_q ? RUN : timer_q >= ST_LIM ? ERR : WAIT_BUSY;
            RUN:       state_d = !bus.busy ? DONE : timer_q >= RT_LIM ? ERR : RUN;
            default:   state_d = IDLE;
        endcase
    end
    always_comb begin
        grant_d = take ? (win ? 2'b10 : 2'b01) : fin ? 2'b00 : grant_q;
        len_d   = take ? win_len : len_q;
        op_d    = take ? win_op : op_q;
        ir_d    = take ? win_ir : ir_q;
        wr_d    = state_q == LOAD && !bus.full_ir;
        wdata_d = wr_d ? ir_q : wdata_q;
        work_d  = state_q == START;
        done_d  = state_q == RUN && !bus.busy ? grant_q : 2'b00;
        err_d   = state_q == ERR ? grant_q : 2'b00;
        rr_d    = fin ? !grant_q[1] : rr_q;
        cnt_d   = cnt_q + 16'(state_q == DONE);
        timer_d = timing && !(state_q == WAIT_BUSY && state_d == RUN) ? timer_q + 16'(!(&timer_q)) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= 1'b0;
            op_q    <= 1'b0;
            work_q  <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            ir_q    <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            op_q    <= op_d;
            work_q  <= work_d;
            wr_q    <= wr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            ir_q    <= ir_d;
            wdata_q <= wdata_d;
        end
    end
    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.len        = len_q;
    assign bus.op         = op_q;
    assign bus.work       = work_q;
    assign bus.wr_ir      = wr_q;
    assign bus.wdata_ir   = wdata_q;
    assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_jtag_scheduler.sv
// tb_jtag_scheduler: transaction-level model of arbitration, latency and timeouts vs the scheduler
module tb_jtag_scheduler;
    localparam int ST = 8;
    localparam int RT = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int rr_m = 0;
    int xfer_m = 0;
    jtag_scheduler_if #(.DATA_INSTRACTION(10)) bus ();
    jtag_scheduler #(.DATA_INSTRACTION(10), .START_TIMEOUT(ST), .RUN_TIMEOUT(RT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    // Drives one transaction from an IDLE cycle (cycle 0) and checks event times against
    // the latencies and timeouts derived from the engine behaviour chosen here.
    // rise: cycles from work to busy high (0 = never); hold: busy-high cycles (-1 = stuck).
    task automatic txn(input logic [1:0] mask, input logic [1:0] ops, input logic [15:0] l0, l1,
                       input logic [9:0] i0, i1, input int rise, input int hold, input int stall);
        int win, w_exp, end_exp, t_end, t_wr, n_wr, t_work, n_work, n_done;
        logic [1:0] g1, dv, ev, oh;
        logic [15:0] lw, len_seen;
        logic [9:0] wd;
        logic op_seen, wop, ok;
        win = (mask == 2'b11) ? rr_m : (mask == 2'b10 ? 1 : 0);
        oh = (win == 1) ? 2'b10 : 2'b01;
        lw = (win == 1) ? l1 : l0;
        wop = ops[win];
        {t_end, t_wr, n_wr, t_work, n_work, n_done} = '0;
        {g1, dv, ev, len_seen, wd, op_seen} = '0;
        bus.req = mask; bus.req_op = ops;
        bus.req_len0 = l0; bus.req_len1 = l1; bus.req_ir0 = i0; bus.req_ir1 = i1;
        bus.busy = 1'b0; bus.full_ir = stall > 0;
        for (int t = 1; t <= 300; t++) begin
            @(negedge clk);
            if (t == 1) g1 = bus.grant;
            if (bus.wr_ir) begin n_wr++; t_wr = t; wd = bus.wdata_ir; end
            if (bus.work) begin n_work++; t_work = t; len_seen = bus.len; op_seen = bus.op; end
            if (|bus.done) n_done++;
            bus.busy = t_work > 0 && rise > 0 && t >= t_work + rise && (hold < 0 || t < t_work + rise + hold);
            bus.full_ir = t <= stall;
            if (|bus.done || |bus.err) begin t_end = t; dv = bus.done; ev = bus.err; break; end
        end
        ok = lw != 0 && rise > 0 && hold >= 0;
        w_exp = wop ? 2 : stall + 3;
        end_exp = lw == 0 ? 2 : rise == 0 ? w_exp + ST : hold < 0 ? w_exp + rise + RT + 2 : w_exp + rise + hold + 1;
        check("grant_at_1", g1, oh);
        check("end_cycle", t_end, end_exp);
        check("done_vec", dv, ok ? oh : 2'b00);
        check("err_vec", ev, ok ? 2'b00 : oh);
        check("done_count", n_done, ok ? 1 : 0);
        check("wr_count", n_wr, (lw != 0 && !wop) ? 1 : 0);
        check("work_count", n_work, lw != 0 ? 1 : 0);
        if (lw != 0) begin
            check("work_cycle", t_work, w_exp);
            check("len_out", len_seen, lw);
            check("op_out", op_seen, wop);
            if (!wop) begin
                check("wr_cycle", t_wr, stall + 2);
                check("wr_data", wd, (win == 1) ? i1 : i0);
            end
        end
        if (ok) begin
            xfer_m++;
            @(negedge clk);
            bus.busy = 1'b0;
            check("done_one_cycle", bus.done, 2'b00);
        end
        check("grant_cleared", bus.grant, 2'b00);
        check("xfer_count", bus.xfer_count, xfer_m & 16'hFFFF);
        rr_m = 1 - win;
    endtask
    initial begin
        int n_ev;
        bus.req = '0; bus.req_op = '0; bus.req_len0 = '0; bus.req_len1 = '0;
        bus.req_ir0 = '0; bus.req_ir1 = '0; bus.busy = 1'b0; bus.full_ir = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_done_err", {bus.done, bus.err}, 4'b0);
        check("rst_len_op", {bus.len, bus.op}, 17'b0);
        check("rst_work_wr", {bus.work, bus.wr_ir}, 2'b0);
        check("rst_wdata", bus.wdata_ir, 10'h0);
        check("rst_xfer", bus.xfer_count, 16'h0);
        rst = 1'b0;
        txn(2'b01, 2'b00, 16'd10, 16'd0, 10'h2A5, 10'h0, 2, 12, 0);
        repeat (4) txn(2'b11, 2'b11, 16'd8, 16'd8, 10'h0, 10'h0, 2, 3, 0);
        txn(2'b01, 2'b00, 16'd20, 16'd0, 10'h155, 10'h0, 3, 5, 5);
        txn(2'b10, 2'b00, 16'd0, 16'd30, 10'h0, 10'h0F0, 0, 0, 0);
        txn(2'b01, 2'b11, 16'd16, 16'd0, 10'h0, 10'h0, 2, -1, 0);
        txn(2'b10, 2'b00, 16'd5, 16'd0, 10'h0, 10'h3FF, 1, 1, 0);
        for (int i = 0; i < 80; i++) begin
            txn(2'($urandom_range(1, 3)), 2'($urandom),
                $urandom_range(0, 7) == 0 ? 16'd0 : 16'($urandom_range(1, 65535)),
                $urandom_range(0, 7) == 0 ? 16'd0 : 16'($urandom_range(1, 65535)),
                10'($urandom), 10'($urandom),
                $urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 4)),
                $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(1, 12)),
                int'($urandom_range(0, 3)));
        end
        bus.req = 2'b01; bus.req_op = 2'b11; bus.req_len0 = 16'd8; bus.busy = 1'b0; bus.full_ir = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_work", bus.work, 1'b1);
        bus.busy = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_grant", bus.grant, 2'b00);
        check("midrst_done_err", {bus.done, bus.err}, 4'b0);
        check("midrst_len_op", {bus.len, bus.op}, 17'b0);
        check("midrst_work_wr", {bus.work, bus.wr_ir, bus.wdata_ir}, 12'b0);
        check("midrst_xfer", bus.xfer_count, 16'h0);
        rst = 1'b0; bus.req = 2'b00; bus.busy = 1'b0;
        n_ev = 0;
        repeat (6) begin
            @(negedge clk);
            if (|bus.done || |bus.err || |bus.grant) n_ev++;
        end
        check("post_rst_quiet", n_ev, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
